// File: rtl/gate_access_sched.sv
// rtl/gate_access_sched.sv - round-robin gate scheduler for two lanes with open window and clearance gap
// Optional served counters enabled by defining GATE_SCHED_STATS_EN.
module gate_access_sched #(
  parameter int OPEN_CYCLES  = 8,
  parameter int CLEAR_CYCLES = 2,
  parameter int CNT_W        = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic       pass,
  output logic [1:0] grant,
  output logic       gate_open,
  output logic       busy,
  output logic       timeout,
  output logic [7:0] served0,
  output logic [7:0] served1
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_GRANT = 2'b01,
    ST_CLEAR = 2'b10,
    ST_BAD   = 2'b11
  } state_e;

  localparam logic [CNT_W-1:0] OPEN_LOAD  = CNT_W'(OPEN_CYCLES - 1);
  localparam logic [CNT_W-1:0] CLEAR_LOAD = CNT_W'(CLEAR_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             last_q, last_d;
  logic [1:0]       grant_q, grant_d;
  logic             gate_open_q, gate_open_d;
  logic             busy_q, busy_d;
  logic             timeout_q, timeout_d;
  logic             lane_sel;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    last_d      = last_q;
    grant_d     = grant_q;
    gate_open_d = gate_open_q;
    busy_d      = busy_q;
    timeout_d   = 1'b0;
    lane_sel    = 1'b0;

    case (state_q)
      ST_IDLE: begin
        grant_d     = 2'b00;
        gate_open_d = 1'b0;
        busy_d      = 1'b0;
        if (req != 2'b00) begin
          // On a tie the lane not served last wins; a single request wins outright.
          lane_sel    = (req == 2'b11) ? ~last_q : req[1];
          grant_d     = lane_sel ? 2'b10 : 2'b01;
          gate_open_d = 1'b1;
          busy_d      = 1'b1;
          cnt_d       = OPEN_LOAD;
          state_d     = ST_GRANT;
        end
      end

      ST_GRANT: begin
        if (pass || (cnt_q == '0)) begin
          timeout_d   = ~pass;
          last_d      = grant_q[1];
          grant_d     = 2'b00;
          gate_open_d = 1'b0;
          cnt_d       = CLEAR_LOAD;
          state_d     = ST_CLEAR;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end

      ST_CLEAR: begin
        grant_d     = 2'b00;
        gate_open_d = 1'b0;
        if (cnt_q == '0) begin
          busy_d  = 1'b0;
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end

      default: begin
        grant_d     = 2'b00;
        gate_open_d = 1'b0;
        busy_d      = 1'b0;
        cnt_d       = '0;
        state_d     = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      last_q      <= 1'b1;
      grant_q     <= 2'b00;
      gate_open_q <= 1'b0;
      busy_q      <= 1'b0;
      timeout_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      last_q      <= last_d;
      grant_q     <= grant_d;
      gate_open_q <= gate_open_d;
      busy_q      <= busy_d;
      timeout_q   <= timeout_d;
    end
  end

  assign grant     = grant_q;
  assign gate_open = gate_open_q;
  assign busy      = busy_q;
  assign timeout   = timeout_q;

`ifdef GATE_SCHED_STATS_EN
  logic [7:0] served0_q, served0_d;
  logic [7:0] served1_q, served1_d;
  logic       served_end;

  // Only pass-terminated windows count; counters hold at 255.
  always_comb begin
    served_end = (state_q == ST_GRANT) && pass;
    served0_d  = served0_q;
    served1_d  = served1_q;
    if (served_end && grant_q[0] && (served0_q != 8'hFF)) served0_d = served0_q + 8'd1;
    if (served_end && grant_q[1] && (served1_q != 8'hFF)) served1_d = served1_q + 8'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      served0_q <= 8'd0;
      served1_q <= 8'd0;
    end else begin
      served0_q <= served0_d;
      served1_q <= served1_d;
    end
  end

  assign served0 = served0_q;
  assign served1 = served1_q;
`else
  assign served0 = 8'd0;
  assign served1 = 8'd0;
`endif

endmodule

// File: tb/tb_gate_access_sched.sv
// tb/tb_gate_access_sched.sv - self-checking bench for gate_access_sched
// Served-count expectations follow GATE_SCHED_STATS_EN.
module tb_gate_access_sched;

  localparam int OPEN = 8;
  localparam int CLR  = 2;
`ifdef GATE_SCHED_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [1:0] req = 2'b00;
  logic       pass = 1'b0;
  logic [1:0] grant;
  logic       gate_open, busy, timeout;
  logic [7:0] served0, served1;

  gate_access_sched #(.OPEN_CYCLES(OPEN), .CLEAR_CYCLES(CLR), .CNT_W(4)) dut (
    .clk(clk), .rst(rst), .req(req), .pass(pass),
    .grant(grant), .gate_open(gate_open), .busy(busy), .timeout(timeout),
    .served0(served0), .served1(served1)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // Reference model: window age counts up, clearance counts remaining cycles.
  int m_lane = -1;
  int m_age = 0;
  int m_clear = 0;
  int m_last = 1;
  int m_s[2];
  bit m_to = 1'b0;

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic void model_edge(input bit r, input logic [1:0] rq, input bit p);
    if (r) begin
      m_lane = -1; m_age = 0; m_clear = 0; m_last = 1; m_to = 1'b0;
      m_s[0] = 0; m_s[1] = 0;
      return;
    end
    m_to = 1'b0;
    if (m_lane >= 0) begin
      if (p || m_age == OPEN) begin
        if (p && STATS && m_s[m_lane] < 255) m_s[m_lane]++;
        m_to = !p;
        m_last = m_lane;
        m_lane = -1;
        m_clear = CLR;
      end else begin
        m_age++;
      end
    end else if (m_clear > 0) begin
      m_clear--;
    end else if (rq != 2'b00) begin
      m_lane = (rq == 2'b11) ? 1 - m_last : (rq[1] ? 1 : 0);
      m_age = 1;
    end
  endfunction

  task automatic compare_model();
    logic [1:0] eg;
    eg = (m_lane < 0) ? 2'b00 : ((m_lane == 1) ? 2'b10 : 2'b01);
    chk("m_grant", {6'd0, grant}, {6'd0, eg});
    chk("m_gate_open", {7'd0, gate_open}, {7'd0, (m_lane >= 0)});
    chk("m_busy", {7'd0, busy}, {7'd0, (m_lane >= 0) || (m_clear > 0)});
    chk("m_timeout", {7'd0, timeout}, {7'd0, m_to});
    chk("m_served0", served0, 8'(m_s[0]));
    chk("m_served1", served1, 8'(m_s[1]));
  endtask

  task automatic step(input bit r, input logic [1:0] rq, input bit p);
    rst = r; req = rq; pass = p;
    @(posedge clk);
    model_edge(r, rq, p);
    #1;
    compare_model();
  endtask

  typedef struct {
    bit         rst;
    logic [1:0] req;
    bit         pass;
    logic [1:0] grant;
    bit         busy;
    bit         to;
    logic [7:0] s0;
    logic [7:0] s1;
  } vec_t;

  vec_t tbl[22];

  function automatic vec_t mk(bit r, logic [1:0] rq, bit p, logic [1:0] g, bit b, bit t, logic [7:0] s0);
    vec_t v;
    v.rst = r; v.req = rq; v.pass = p; v.grant = g; v.busy = b; v.to = t; v.s0 = s0; v.s1 = 8'd0;
    return v;
  endfunction

  initial begin
    #400000000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    logic [1:0] seq[$];
    int gaps[$];
    int gap;
    bit in_win;
    logic [1:0] want[4];

    tbl[0]  = mk(1, 2'b00, 0, 2'b00, 0, 0, 0);
    tbl[1]  = mk(1, 2'b00, 0, 2'b00, 0, 0, 0);
    tbl[2]  = mk(0, 2'b00, 0, 2'b00, 0, 0, 0);
    tbl[3]  = mk(0, 2'b01, 0, 2'b01, 1, 0, 0);
    tbl[4]  = mk(0, 2'b00, 0, 2'b01, 1, 0, 0);
    tbl[5]  = mk(0, 2'b00, 0, 2'b01, 1, 0, 0);
    tbl[6]  = mk(0, 2'b00, 1, 2'b00, 1, 0, 1);
    tbl[7]  = mk(0, 2'b00, 0, 2'b00, 1, 0, 1);
    tbl[8]  = mk(0, 2'b00, 0, 2'b00, 0, 0, 1);
    for (int i = 9; i <= 16; i++) tbl[i] = mk(0, 2'b10, 0, 2'b10, 1, 0, 1);
    tbl[17] = mk(0, 2'b10, 0, 2'b00, 1, 1, 1);
    tbl[18] = mk(0, 2'b10, 0, 2'b00, 1, 0, 1);
    tbl[19] = mk(0, 2'b10, 0, 2'b00, 0, 0, 1);
    tbl[20] = mk(0, 2'b10, 0, 2'b10, 1, 0, 1);
    tbl[21] = mk(1, 2'b00, 0, 2'b00, 0, 0, 0);

    for (int i = 0; i < 22; i++) begin
      step(tbl[i].rst, tbl[i].req, tbl[i].pass);
      chk($sformatf("tbl%0d_grant", i), {6'd0, grant}, {6'd0, tbl[i].grant});
      chk($sformatf("tbl%0d_gate_open", i), {7'd0, gate_open}, {7'd0, tbl[i].grant != 2'b00});
      chk($sformatf("tbl%0d_busy", i), {7'd0, busy}, {7'd0, tbl[i].busy});
      chk($sformatf("tbl%0d_timeout", i), {7'd0, timeout}, {7'd0, tbl[i].to});
      chk($sformatf("tbl%0d_served0", i), served0, STATS ? tbl[i].s0 : 8'd0);
      chk($sformatf("tbl%0d_served1", i), served1, STATS ? tbl[i].s1 : 8'd0);
    end

    // Round-robin with req=11 held and pass on every grant's first cycle.
    step(1, 2'b00, 0);
    in_win = 1'b0; gap = 0;
    for (int c = 0; c < 60 && seq.size() < 4; c++) begin
      step(0, 2'b11, grant != 2'b00);
      if (grant != 2'b00) begin
        if (!in_win && seq.size() > 0) gaps.push_back(gap);
        if (!in_win) seq.push_back(grant);
        in_win = 1'b1; gap = 0;
      end else begin
        in_win = 1'b0; gap++;
      end
    end
    want[0] = 2'b01; want[1] = 2'b10; want[2] = 2'b01; want[3] = 2'b10;
    chk("rr_count", 8'(seq.size()), 8'd4);
    for (int i = 0; i < seq.size() && i < 4; i++) chk($sformatf("rr_seq%0d", i), {6'd0, seq[i]}, {6'd0, want[i]});
    chk("rr_gap_count", 8'(gaps.size()), 8'd3);
    foreach (gaps[i]) chk($sformatf("rr_gap%0d", i), 8'(gaps[i]), 8'd3);

    // Pass on the same edge the window would time out.
    step(1, 2'b00, 0);
    step(0, 2'b01, 0);
    for (int i = 0; i < 7; i++) begin
      chk($sformatf("sim_open%0d", i), {6'd0, grant}, 8'd1);
      step(0, 2'b00, 0);
    end
    chk("sim_open7", {6'd0, grant}, 8'd1);
    step(0, 2'b00, 1);
    chk("sim_grant_end", {6'd0, grant}, 8'd0);
    chk("sim_no_timeout", {7'd0, timeout}, 8'd0);
    chk("sim_served0", served0, STATS ? 8'd1 : 8'd0);
    step(0, 2'b00, 0);
    chk("sim_no_timeout_after", {7'd0, timeout}, 8'd0);

    // Mid-grant reset restores lane-0 priority.
    step(1, 2'b00, 0);
    step(0, 2'b01, 0);
    step(0, 2'b00, 1);
    for (int i = 0; i < 3; i++) step(0, 2'b00, 0);
    step(0, 2'b11, 0);
    chk("mr_lane1", {6'd0, grant}, 8'd2);
    for (int i = 0; i < 3; i++) step(0, 2'b00, 0);
    chk("mr_4th_cycle", {6'd0, grant}, 8'd2);
    step(1, 2'b00, 0);
    chk("mr_grant", {6'd0, grant}, 8'd0);
    chk("mr_busy", {7'd0, busy}, 8'd0);
    chk("mr_timeout", {7'd0, timeout}, 8'd0);
    step(0, 2'b11, 0);
    chk("mr_regrant", {6'd0, grant}, 8'd1);

    // Randomized traffic against the model.
    step(1, 2'b00, 0);
    for (int i = 0; i < 3000; i++)
      step(($urandom_range(0, 199) == 0), 2'($urandom_range(0, 3)), ($urandom_range(0, 3) == 0));

    // Saturation of the lane-0 counter.
    step(1, 2'b00, 0);
    for (int i = 0; i < 1100; i++) step(0, 2'b01, 1);
    chk("sat_served0", served0, STATS ? 8'd255 : 8'd0);
    chk("sat_served1", served1, 8'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
